wt_dcache_inval_queue: RTL
==========================

# wt_dcache_inval_queue

Buffers and coalesces cache-line invalidation requests arriving from the bus adapter and presents them one at a time to the dcache invalidation unit's request/ack port. It sits directly upstream of the invalidation unit: its output handshake drives `mem_inv_req_i`/`mem_inv_paddr_i` and consumes `mem_inv_ack_o`. This decouples bus-side invalidation bursts from cache-port arbitration.

## Interface
- `ArianeCfg`, default `ariane_pkg::ArianeDefaultConfig`: core configuration; carried for consistency, no field used.
- `DEPTH`, default `wt_cache_pkg::DCACHE_INVAL_QUEUE_DEPTH` (4): number of entries; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `inv_vld_i` in 1: bus invalidation request valid.
- `inv_paddr_i` in `riscv::PLEN`: physical address to invalidate; offset bits are ignored.
- `inv_rdy_o` out 1: queue can accept a request.
- `flush_i` in 1: discard all pending entries.
- `mem_inv_req_o` out 1: request to the invalidation unit.
- `mem_inv_paddr_o` out `riscv::PLEN`: line-aligned address of the head entry.
- `mem_inv_ack_i` in 1: invalidation unit accepted the head entry.
- `merged_o` out 1: one-cycle pulse; the accepted request was coalesced.
- `cnt_o` out `$clog2(DEPTH)+1`: number of valid entries.

## Operation
- Storage is a circular buffer of `DEPTH` line addresses, each `PLEN-DCACHE_OFFSET_WIDTH` bits, with read pointer, write pointer, and count registers.
- Accept: `inv_vld_i & inv_rdy_o`.
- `inv_rdy_o = (cnt_q != DEPTH)`. It is registered-state only, with no combinational path from `inv_vld_i`, `mem_inv_ack_i` or the tag compare.
- Coalesce: an accepted line address that equals any valid entry is dropped, and `merged_o` is asserted.
  - Exception: the head entry does not count as a match in a cycle where it is being popped (`mem_inv_req_o & mem_inv_ack_i`). In that case the new request is pushed.
  - Reason: the popped entry's lookup has already been taken, so a later invalidation must be re-executed.
- Push otherwise: write at `wptr`, then `wptr+1` modulo `DEPTH`, `cnt+1`.
- Pop: on `mem_inv_req_o & mem_inv_ack_i`, `rptr+1` modulo `DEPTH`, `cnt-1`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Output: `mem_inv_req_o = (cnt_q != 0)`. `mem_inv_paddr_o = {head_line, DCACHE_OFFSET_WIDTH'(0)}`.
- Flush: next cycle `cnt`, `rptr` and `wptr` are 0.
  - A request accepted in the flush cycle is discarded, and `merged_o` stays 0.
  - An ack in the flush cycle is absorbed with no further effect.
- Req/ack rule: once raised, `mem_inv_req_o` and `mem_inv_paddr_o` hold stable until ack; flush is the only exception.
  - Dropping the request on flush is legal because the invalidation unit only changes state on the ack cycle.
- Pointer wrap: pointers are `$clog2(DEPTH)` bits and wrap naturally; full and empty are decided by `cnt`, never by pointer equality.

## Timing
- Reset values: `inv_rdy_o`=1, `mem_inv_req_o`=0, `mem_inv_paddr_o`=0, `merged_o`=0, `cnt_o`=0. Storage contents are don't-care; reset them to 0 anyway for X-cleanliness.
- Latency: a request accepted in cycle N (queue empty) produces `mem_inv_req_o`=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: one pop per cycle when the downstream acks every cycle. With the downstream unit's read-then-lookup sequence, the sustained rate is one pop per 2+ cycles.
- `merged_o` is combinational from the accept cycle.
- `inv_rdy_o` falls in the cycle after the push that makes `cnt`=`DEPTH`. It rises in the cycle after the first pop or flush.
- Reset mid-operation: all entries are lost immediately and asynchronously; `mem_inv_req_o` deasserts without an ack.

## Structure
- Add `DCACHE_INVAL_QUEUE_DEPTH` (localparam, 4) to `wt_cache_pkg`.
- Add to `wt_cache_pkg` the typedef `inval_line_t` (`logic [riscv::PLEN-DCACHE_OFFSET_WIDTH-1:0]`).
- The coalescing compare needs parallel access to every entry, so storage is implemented inline rather than using a generic FIFO.
- One sub-module is natural: `wt_dcache_inval_match`, a combinational `DEPTH`-way comparator. It takes the entry array, the valid vector, the popping-head mask and the incoming line, and returns `hit`.
- The top instantiates it between `wt_dcache_wbuf`'s neighbours and `wt_dcache_inval`.

## Test plan
- Single request: push 0x8000_1044 into an empty queue, ack on the 2nd cycle of req → `mem_inv_paddr_o`=0x8000_1040, req high 2 cycles, `cnt_o` 0→1→0.
- Coalesce: push 0x100, 0x200, 0x108 with no acks → `merged_o` pulses on the third push, `cnt_o`=2, pops return 0x100 then 0x200.
- Full/wrap:
  - Push 0x40·k for k=0..3 with no acks → `inv_rdy_o`=0 and `cnt_o`=4.
  - Then ack one and push 0x500 → order 0x40,0x80,0xC0,0x500; wptr wraps to 1.
- Head-pop race: head=0x300 being acked while 0x300 arrives → pushed, `merged_o`=0, `cnt_o` unchanged, next head reaches 0x300 again.
- Flush: 3 entries queued, flush_i together with a push of 0x900 → next cycle `cnt_o`=0, `mem_inv_req_o`=0, 0x900 never presented.
- Async reset mid-burst with 2 entries: `rst_ni` low between edges → `mem_inv_req_o`=0 and `cnt_o`=0 immediately, `inv_rdy_o`=1.

Source files
------------

// File: rtl/wt_dcache_inval_queue_pkg.sv
// Shared types and constants for the dcache invalidation queue slice.
// Line addresses are stored without offset bits.
package wt_dcache_inval_queue_pkg;

    localparam int unsigned PLEN                     = 56;
    localparam int unsigned DCACHE_OFFSET_WIDTH      = 4;
    localparam int unsigned DCACHE_INVAL_QUEUE_DEPTH = 4;

    typedef logic [PLEN-DCACHE_OFFSET_WIDTH-1:0] inval_line_t;

    typedef struct packed {
        logic [63:0] dram_base;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{dram_base: 64'h8000_0000};

endpackage

// File: rtl/wt_dcache_inval_match.sv
// Parallel DEPTH-way line-address comparator used to coalesce incoming invalidations.
// A head entry that is being popped this cycle is masked out of the match.
module wt_dcache_inval_match
    import wt_dcache_inval_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DCACHE_INVAL_QUEUE_DEPTH
) (
    input  inval_line_t [DEPTH-1:0] entries_i,
    input  logic        [DEPTH-1:0] valid_i,
    input  logic        [DEPTH-1:0] pop_mask_i,
    input  inval_line_t             line_i,
    output logic                    hit_c_o
);

    always_comb begin
        hit_c_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && !pop_mask_i[i] && (entries_i[i] == line_i)) begin
                hit_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_inval_queue.sv
// Coalescing circular buffer of cache-line invalidations feeding the dcache
// invalidation unit through a req/ack port.
module wt_dcache_inval_queue
    import wt_dcache_inval_queue_pkg::*;
#(
    parameter ariane_cfg_t ArianeCfg = ArianeDefaultConfig,
    parameter int unsigned DEPTH     = DCACHE_INVAL_QUEUE_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   inv_vld_i,
    input  logic [PLEN-1:0]        inv_paddr_i,
    output logic                   inv_rdy_o,
    input  logic                   flush_i,
    output logic                   mem_inv_req_o,
    output logic [PLEN-1:0]        mem_inv_paddr_o,
    input  logic                   mem_inv_ack_i,
    output logic                   merged_o,
    output logic [$clog2(DEPTH):0] cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Configuration is carried through for interface compatibility only.
    localparam int unsigned unused_cfg_w = $bits(ArianeCfg);

    inval_line_t [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DEPTH-1:0]        valid, pop_mask;
    inval_line_t             in_line;
    logic                    accept, pop, push, hit;
    logic                    unused_offset;

    assign in_line       = inv_paddr_i[PLEN-1:DCACHE_OFFSET_WIDTH];
    assign unused_offset = ^inv_paddr_i[DCACHE_OFFSET_WIDTH-1:0];

    assign inv_rdy_o       = (cnt_q != CntW'(DEPTH));
    assign mem_inv_req_o   = (cnt_q != '0);
    assign mem_inv_paddr_o = {mem_q[rptr_q], DCACHE_OFFSET_WIDTH'(0)};
    assign cnt_o           = cnt_q;

    assign accept   = inv_vld_i & inv_rdy_o;
    assign pop      = mem_inv_req_o & mem_inv_ack_i;
    assign push     = accept & ~hit & ~flush_i;
    assign merged_o = accept & hit & ~flush_i;

    // Occupancy is derived from distance to the read pointer, so full/empty never depend on pointer equality.
    always_comb begin
        valid    = '0;
        pop_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i]    = CntW'(PtrW'(PtrW'(i) - rptr_q)) < cnt_q;
            pop_mask[i] = pop && (rptr_q == PtrW'(i));
        end
    end

    wt_dcache_inval_match #(
        .DEPTH(DEPTH)
    ) i_match (
        .entries_i (mem_q),
        .valid_i   (valid),
        .pop_mask_i(pop_mask),
        .line_i    (in_line),
        .hit_c_o   (hit)
    );

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            mem_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= in_line;
        end
    end

endmodule
